// File: rtl/frame_rate_timer_if.sv
// Control/status bundle of frame_rate_timer: run/pause/step controls in, tick and timing status out.
interface frame_rate_timer_if #(
    parameter int CNT_W = 26,
    parameter int FC_W  = 16
) ();
    logic             enable;
    logic             step;
    logic [3:0]       rate_sel;
    logic             count_clr;
    logic             frame_tick;
    logic [3:0]       active_sel;
    logic [CNT_W-1:0] remaining;
    logic [FC_W-1:0]  frame_count;

    modport master (
        output enable, step, rate_sel, count_clr,
        input  frame_tick, active_sel, remaining, frame_count
    );

    modport slave (
        input  enable, step, rate_sel, count_clr,
        output frame_tick, active_sel, remaining, frame_count
    );
endinterface

// File: rtl/frame_rate_timer.sv
// Frame-rate tick generator: divides clock to 60..1 FPS, supports pause/step and boundary-only rate changes.
// Optional running frame counter enabled by defining FRAME_TIMER_COUNT_EN.
module frame_rate_timer #(
    parameter int CLK_HZ    = 50000000,
    parameter int CNT_W     = 26,
    parameter int FC_W      = 16,
    parameter int RESET_SEL = 11
) (
    input  logic              clock,
    input  logic              reset,
    frame_rate_timer_if.slave bus
);

    // Each branch folds to a constant, so this is a small mux rather than a divider.
    function automatic logic [CNT_W-1:0] reload_of(input logic [3:0] idx);
        logic [CNT_W-1:0] r;
        case (idx)
            4'd0:    r = CNT_W'(CLK_HZ / 60 - 1);
            4'd1:    r = CNT_W'(CLK_HZ / 55 - 1);
            4'd2:    r = CNT_W'(CLK_HZ / 50 - 1);
            4'd3:    r = CNT_W'(CLK_HZ / 45 - 1);
            4'd4:    r = CNT_W'(CLK_HZ / 40 - 1);
            4'd5:    r = CNT_W'(CLK_HZ / 35 - 1);
            4'd6:    r = CNT_W'(CLK_HZ / 30 - 1);
            4'd7:    r = CNT_W'(CLK_HZ / 25 - 1);
            4'd8:    r = CNT_W'(CLK_HZ / 20 - 1);
            4'd9:    r = CNT_W'(CLK_HZ / 15 - 1);
            4'd10:   r = CNT_W'(CLK_HZ / 10 - 1);
            4'd11:   r = CNT_W'(CLK_HZ / 5 - 1);
            default: r = CNT_W'(CLK_HZ - 1);
        endcase
        return r;
    endfunction

    localparam logic [3:0] RST_SEL = 4'(RESET_SEL);

    logic [CNT_W-1:0] remaining;
    logic [3:0]       active_sel;
    logic             frame_tick;
    logic             reload;

    // A reload either ends a running frame or is a single step while paused.
    always_comb begin
        reload = (bus.enable && (remaining == '0)) || (!bus.enable && bus.step);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining  <= reload_of(RST_SEL);
            active_sel <= RST_SEL;
            frame_tick <= 1'b0;
        end else if (reload) begin
            remaining  <= reload_of(bus.rate_sel);
            active_sel <= bus.rate_sel;
            frame_tick <= 1'b1;
        end else begin
            if (bus.enable) begin
                remaining <= remaining - 1'b1;
            end
            frame_tick <= 1'b0;
        end
    end

    assign bus.remaining  = remaining;
    assign bus.active_sel = active_sel;
    assign bus.frame_tick = frame_tick;

`ifdef FRAME_TIMER_COUNT_EN
    logic [FC_W-1:0] frame_count;

    // The count advances on the edge ending a tick cycle, so a clear in that cycle wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (bus.count_clr) begin
            frame_count <= '0;
        end else if (frame_tick) begin
            frame_count <= frame_count + 1'b1;
        end
    end

    assign bus.frame_count = frame_count;
`else
    assign bus.frame_count = '0;
`endif

endmodule

// File: tb/tb_frame_rate_timer.sv
// Directed self-checking bench for frame_rate_timer at CLK_HZ=1200 (P: 60 FPS=20, 50 FPS=24, 1 FPS=1200).
module tb_frame_rate_timer;

    localparam int CLK_HZ = 1200;
    localparam int CNT_W  = 11;
`ifdef FRAME_TIMER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   n;
    int   ticks;
    logic stuck;

    always #5 clock = ~clock;

    frame_rate_timer_if #(.CNT_W(CNT_W), .FC_W(16)) bus ();
    frame_rate_timer_if #(.CNT_W(CNT_W), .FC_W(2))  bus2 ();

    assign bus2.enable    = bus.enable;
    assign bus2.step      = bus.step;
    assign bus2.rate_sel  = bus.rate_sel;
    assign bus2.count_clr = bus.count_clr;

    frame_rate_timer #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .FC_W(16), .RESET_SEL(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    frame_rate_timer #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .FC_W(2), .RESET_SEL(0)) dut_wrap (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected frame count, accounting for the counter being compiled out.
    function automatic int efc(input int v, input int w);
        return CNT_EN ? (v % (1 << w)) : 0;
    endfunction

    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    // Edges until frame_tick is seen (this edge counted), or -1 on timeout.
    task automatic wait_tick(output int cnt, input int budget);
        cnt = 0;
        do begin
            edge1();
            cnt++;
        end while (!bus.frame_tick && cnt < budget);
        if (!bus.frame_tick) cnt = -1;
    endtask

    task automatic wait_remaining(input int target, input string tag);
        int k = 0;
        while (int'(bus.remaining) != target && k < 2000) begin
            edge1();
            k++;
        end
        check(tag, int'(bus.remaining), target);
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.step      = 1'b0;
        bus.rate_sel  = 4'd0;
        bus.count_clr = 1'b0;

        // Reset defaults
        edge1(); edge1(); edge1();
        check("rst_remaining",  int'(bus.remaining), 19);
        check("rst_active_sel", int'(bus.active_sel), 0);
        check("rst_tick",       int'(bus.frame_tick), 0);
        check("rst_count",      int'(bus.frame_count), 0);
        reset = 1'b0;
        bus.enable = 1'b1;

        wait_tick(n, 2000);
        check("first_tick_edges", n, 20);
        check("first_tick_remaining", int'(bus.remaining), 19);
        for (int i = 0; i < 4; i++) begin
            wait_tick(n, 2000);
            check("tick_period_20", n, 20);
        end
        edge1();
        check("count_after_5", int'(bus.frame_count), efc(5, 16));
        check("wrap_count_after_5", int'(bus2.frame_count), efc(5, 2));

        // Rate change mid-frame takes effect only at the boundary
        wait_remaining(10, "reach_rem_10");
        bus.rate_sel = 4'd2;
        wait_tick(n, 2000);
        check("rate_chg_frame_end", n, 11);
        check("rate_chg_active_sel", int'(bus.active_sel), 2);
        check("rate_chg_remaining", int'(bus.remaining), 23);
        wait_tick(n, 2000);
        check("rate_chg_period_24", n, 24);

        // Pause freezes remaining; resume loses no cycles
        wait_remaining(7, "reach_rem_7");
        bus.enable = 1'b0;
        ticks = 0;
        stuck = 1'b1;
        for (int i = 0; i < 50; i++) begin
            edge1();
            if (bus.frame_tick) ticks++;
            if (int'(bus.remaining) != 7) stuck = 1'b0;
        end
        check("pause_no_tick", ticks, 0);
        check("pause_frozen", int'(stuck), 1);
        bus.enable = 1'b1;
        wait_tick(n, 2000);
        check("resume_edges", n, 8);

        // Single-step while paused
        bus.enable = 1'b0;
        edge1();
        check("count_before_step", int'(bus.frame_count), efc(8, 16));
        for (int i = 0; i < 3; i++) begin
            bus.step = 1'b1;
            edge1();
            bus.step = 1'b0;
            check("step_tick", int'(bus.frame_tick), 1);
            check("step_remaining", int'(bus.remaining), 23);
            edge1();
            check("step_tick_low", int'(bus.frame_tick), 0);
        end
        check("count_after_steps", int'(bus.frame_count), efc(11, 16));
        check("wrap_count_after_steps", int'(bus2.frame_count), efc(11, 2));

        // step ignored while enabled
        bus.enable = 1'b1;
        bus.step   = 1'b1;
        ticks = 0;
        for (int i = 0; i < 3; i++) begin
            edge1();
            if (bus.frame_tick) ticks++;
        end
        bus.step = 1'b0;
        check("step_enabled_no_tick", ticks, 0);
        check("step_enabled_remaining", int'(bus.remaining), 20);

        // Clear coincident with the count update, then wrap of the 2-bit counter
        wait_tick(n, 2000);
        check("clr_tick_edges", n, 21);
        bus.count_clr = 1'b1;
        edge1();
        bus.count_clr = 1'b0;
        check("clr_collision", int'(bus.frame_count), 0);
        check("clr_collision_wrap", int'(bus2.frame_count), 0);
        for (int i = 1; i <= 4; i++) begin
            wait_tick(n, 2000);
            check("wrap_period", n, 23);
            edge1();
            check("wrap_seq", int'(bus2.frame_count), efc(i, 2));
            check("count_seq", int'(bus.frame_count), efc(i, 16));
        end

        // Asynchronous reset mid-frame, then out-of-range rate index
        wait_remaining(5, "reach_rem_5");
        reset = 1'b1;
        #1;
        check("async_rst_remaining", int'(bus.remaining), 19);
        check("async_rst_active_sel", int'(bus.active_sel), 0);
        check("async_rst_count", int'(bus.frame_count), 0);
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            edge1();
            if (bus.frame_tick) ticks++;
        end
        check("async_rst_no_tick", ticks, 0);
        bus.rate_sel = 4'd14;
        reset = 1'b0;
        wait_tick(n, 2000);
        check("post_rst_first_tick", n, 20);
        check("oob_active_sel", int'(bus.active_sel), 14);
        check("oob_remaining", int'(bus.remaining), 1199);
        wait_tick(n, 2000);
        check("oob_period_1200", n, 1200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
